// File: rtl/pio_seq_pkg.sv
// Shared definitions for the PIO master sequencer.
//   - Command op codes carried on cmd_op.
//   - Register offsets of the 8-bit bidirectional PIO slave.
//   - Sequencer FSM state encoding.
//   - PIO data width.
package pio_seq_pkg;

  localparam int PIO_W = 8;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_POLL  = 3'd2;
  localparam logic [2:0] OP_SET   = 3'd3;
  localparam logic [2:0] OP_CLR   = 3'd4;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_DIR  = 3'd1;
  localparam logic [2:0] REG_SET  = 3'd4;
  localparam logic [2:0] REG_CLR  = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_A,
    RD_D,
    PG,
    PA,
    PD,
    RSP
  } state_e;

endpackage

// File: rtl/pio_master_seq.sv
// Avalon-MM initiator that turns simple commands into bus cycles on the
// 8-bit bidirectional PIO slave (data, direction, bit-set, bit-clear).
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; accepted when both are high
//   cmd_op/addr/data/mask  command fields (WRITE, READ, POLL, SET, CLR)
//   rsp_valid              one-cycle strobe for READ and POLL results
//   rsp_data, rsp_timeout  result sample and poll-gave-up flag (held)
//   address, chipselect,   Avalon master signals to the slave s1 port
//   write_n, writedata
//   readdata               slave read data, valid one cycle after address
//
// Parameters:
//   POLL_TIMEOUT  max poll read iterations before giving up (1..65535)
//   POLL_GAP      idle cycles between successive poll reads (0..255)
//
// Build option:
//   PIO_MASTER_SEQ_TIMEOUT_EN  when defined, POLL gives up after
//   POLL_TIMEOUT reads; otherwise it waits for a match indefinitely and
//   rsp_timeout is always 0.
//
// All outputs are registered: bus and handshake values are computed for the
// next state and loaded together with it.
module pio_master_seq
  import pio_seq_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1024,
  parameter int POLL_GAP     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_addr,
  input  logic [PIO_W-1:0] cmd_data,
  input  logic [PIO_W-1:0] cmd_mask,
  output logic             rsp_valid,
  output logic [PIO_W-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic [2:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata
);

  localparam logic [7:0] GAP_LAST = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [PIO_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_to_q, rsp_to_d;
  logic [2:0]       addr_q, addr_d;
  logic             cs_q, cs_d;
  logic             wn_q, wn_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [PIO_W-1:0] data_q, data_d;
  logic [PIO_W-1:0] mask_q, mask_d;
  logic [7:0]       gap_q, gap_d;
  logic [PIO_W-1:0] sample;
  logic             hit;
  logic             accept;
  logic             unused_rdata;

`ifdef PIO_MASTER_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(POLL_TIMEOUT);
  logic [15:0] iter_q, iter_d, iter_inc;
  assign iter_inc = iter_q + 16'd1;
`else
  localparam int unused_poll_timeout = POLL_TIMEOUT;
`endif

  assign sample       = readdata[PIO_W-1:0];
  assign unused_rdata = ^readdata[31:PIO_W];
  // A zero mask bit excludes that bit, so mask=0 matches immediately.
  assign hit          = ((sample ^ data_q) & mask_q) == '0;
  assign accept       = cmd_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    cs_d       = 1'b0;
    wn_d       = 1'b1;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_to_d   = rsp_to_q;
    data_d     = data_q;
    mask_d     = mask_q;
    gap_d      = gap_q;
`ifdef PIO_MASTER_SEQ_TIMEOUT_EN
    iter_d     = iter_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Op and address go straight into the bus registers; only the
          // poll compare value and mask are needed later.
          data_d = cmd_data;
          mask_d = cmd_mask;
`ifdef PIO_MASTER_SEQ_TIMEOUT_EN
          iter_d = '0;
`endif
          case (cmd_op)
            OP_WRITE, OP_SET, OP_CLR: begin
              state_d = WR;
              cs_d    = 1'b1;
              wn_d    = 1'b0;
              wdata_d = 32'(cmd_data);
              addr_d  = (cmd_op == OP_SET) ? REG_SET :
                        (cmd_op == OP_CLR) ? REG_CLR : cmd_addr;
            end
            OP_READ: begin
              state_d = RD_A;
              cs_d    = 1'b1;
              addr_d  = cmd_addr;
            end
            OP_POLL: begin
              state_d = PA;
              cs_d    = 1'b1;
              addr_d  = REG_DATA;
            end
            default: ; // reserved ops: consumed, no bus cycle, no response
          endcase
        end
      end
      WR:   state_d = IDLE;
      RD_A: state_d = RD_D;
      RD_D: begin
        rsp_data_d = sample;
        rsp_to_d   = 1'b0;
        state_d    = RSP;
      end
      PA:   state_d = PD;
      PD: begin
`ifdef PIO_MASTER_SEQ_TIMEOUT_EN
        iter_d = iter_inc;
`endif
        if (hit) begin
          rsp_data_d = sample;
          rsp_to_d   = 1'b0;
          state_d    = RSP;
        end
`ifdef PIO_MASTER_SEQ_TIMEOUT_EN
        else if (iter_inc == TO_LAST) begin
          rsp_data_d = sample;
          rsp_to_d   = 1'b1;
          state_d    = RSP;
        end
`endif
        else if (POLL_GAP > 0) begin
          gap_d   = '0;
          state_d = PG;
        end else begin
          state_d = PA;
          cs_d    = 1'b1;
          addr_d  = REG_DATA;
        end
      end
      PG: begin
        if (gap_q == GAP_LAST) begin
          state_d = PA;
          cs_d    = 1'b1;
          addr_d  = REG_DATA;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      wdata_q     <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      gap_q       <= '0;
`ifdef PIO_MASTER_SEQ_TIMEOUT_EN
      iter_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      gap_q       <= gap_d;
`ifdef PIO_MASTER_SEQ_TIMEOUT_EN
      iter_q      <= iter_d;
`endif
    end
  end

  assign cmd_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_to_q;
  assign address     = addr_q;
  assign chipselect  = cs_q;
  assign write_n     = wn_q;
  assign writedata   = wdata_q;

endmodule

// File: tb/tb_pio_master_seq.sv
// Directed bench for pio_master_seq paired with a behavioural model of the
// 8-bit bidirectional PIO slave (data/dir/set/clr, registered readdata).
module tb_pio_master_seq;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_GAP     = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [2:0]  cmd_addr = 3'd0;
  logic [7:0]  cmd_data = 8'h00;
  logic [7:0]  cmd_mask = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_timeout;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata = 32'h0;

  int checks = 0;
  int errors = 0;

  pio_master_seq #(.POLL_TIMEOUT(TB_TIMEOUT), .POLL_GAP(TB_GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // PIO slave model
  logic [7:0] pio_out = 8'h00;
  logic [7:0] pio_dir = 8'h00;
  logic [7:0] ext_pins = 8'h00;
  logic [7:0] pins;
  assign pins = (pio_out & pio_dir) | (ext_pins & ~pio_dir);

  always @(posedge clk) begin
    if (chipselect && !write_n) begin
      case (address)
        3'd0: pio_out <= writedata[7:0];
        3'd1: pio_dir <= writedata[7:0];
        3'd4: pio_out <= pio_out | writedata[7:0];
        3'd5: pio_out <= pio_out & ~writedata[7:0];
        default: ;
      endcase
    end
    case (address)
      3'd0:    readdata <= {24'h0, pins};
      3'd1:    readdata <= {24'h0, pio_dir};
      default: readdata <= 32'h0;
    endcase
  end

  // Bus monitor (cumulative; tasks read it #1 after a falling edge)
  int ncyc = 0, wr_total = 0, rd_total = 0, rsp_total = 0;
  int wr_run_err = 0, wd_hi_err = 0;
  bit prev_wr = 1'b0;
  int wr_ncyc [64];
  int wr_addr [64];
  int rd_ncyc [256];

  always @(negedge clk) begin
    ncyc++;
    if (chipselect && !write_n) begin
      if (wr_total < 64) begin
        wr_ncyc[wr_total] = ncyc;
        wr_addr[wr_total] = int'(address);
      end
      if (prev_wr) wr_run_err++;
      if (writedata[31:8] != 24'h0) wd_hi_err++;
      wr_total++;
    end
    prev_wr = chipselect && !write_n;
    if (chipselect && write_n && address == 3'd0) begin
      if (rd_total < 256) rd_ncyc[rd_total] = ncyc;
      rd_total++;
    end
    if (rsp_valid) rsp_total++;
  end

  // Must be called at a falling edge; returns at the falling edge that
  // follows the accepting rising edge.
  task automatic send(input logic [2:0] op, input logic [2:0] a,
                      input logic [7:0] d, input logic [7:0] m);
    bit ok = 1'b0;
    int n = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
    while (!ok && n < 50) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept op=%0d: cmd_ready not seen in 50 cycles", op);
    end
  endtask

  // Waits (at falling edges) for rsp_valid; lat counts falling edges since
  // the send() return point, which is itself falling edge 1 after accept.
  task automatic wait_rsp(input int limit, output bit got, output int lat);
    got = 1'b0;
    lat = 1;
    while (!got && lat < limit) begin
      if (rsp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 8;
    if (cmd_ready !== 1'b0)   begin errors++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_data !== 8'h00)   begin errors++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", rsp_timeout); end
    if (address !== 3'd0)     begin errors++; $display("FAIL rst_address: got %0d want 0", address); end
    if (chipselect !== 1'b0)  begin errors++; $display("FAIL rst_cs: got %b want 0", chipselect); end
    if (write_n !== 1'b1)     begin errors++; $display("FAIL rst_write_n: got %b want 1", write_n); end
    if (writedata !== 32'h0)  begin errors++; $display("FAIL rst_writedata: got %h want 0", writedata); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk: got %b want 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clk: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    int w0 = wr_total;
    int r0 = rsp_total;
    send(3'd0, 3'd1, 8'hFF, 8'h00);
    send(3'd0, 3'd0, 8'hA5, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    checks += 6;
    if (wr_total - w0 != 2) begin errors++; $display("FAIL wr_count: got %0d want 2", wr_total - w0); end
    if (wr_ncyc[w0+1] - wr_ncyc[w0] != 2) begin errors++; $display("FAIL wr_spacing: got %0d want 2", wr_ncyc[w0+1] - wr_ncyc[w0]); end
    if (pio_dir !== 8'hFF) begin errors++; $display("FAIL wr_dir: got %h want ff", pio_dir); end
    if (pins !== 8'hA5) begin errors++; $display("FAIL wr_port: got %h want a5", pins); end
    if (rsp_total != r0) begin errors++; $display("FAIL wr_no_rsp: got %0d responses want 0", rsp_total - r0); end
    if (wr_run_err != 0) begin errors++; $display("FAIL wr_single_cycle: got %0d long strobes want 0", wr_run_err); end
    @(negedge clk);
  endtask

  task automatic test_set_clr();
    int w0 = wr_total;
    send(3'd3, 3'd7, 8'h0A, 8'h00);
    send(3'd4, 3'd7, 8'h81, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    checks += 4;
    if (wr_total - w0 != 2) begin errors++; $display("FAIL sc_count: got %0d want 2", wr_total - w0); end
    if (wr_addr[w0] != 4) begin errors++; $display("FAIL set_addr: got %0d want 4", wr_addr[w0]); end
    if (wr_addr[w0+1] != 5) begin errors++; $display("FAIL clr_addr: got %0d want 5", wr_addr[w0+1]); end
    if (pins !== 8'h2E) begin errors++; $display("FAIL sc_port: got %h want 2e", pins); end
    @(negedge clk);
  endtask

  task automatic test_reserved();
    int w0 = wr_total;
    int r0 = rsp_total;
    send(3'd6, 3'd0, 8'h55, 8'h00);
    repeat (4) @(negedge clk);
    #1;
    checks += 3;
    if (wr_total != w0) begin errors++; $display("FAIL rsv_no_write: got %0d writes want 0", wr_total - w0); end
    if (rsp_total != r0) begin errors++; $display("FAIL rsv_no_rsp: got %0d responses want 0", rsp_total - r0); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rsv_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_read();
    bit got;
    int lat;
    send(3'd1, 3'd1, 8'h00, 8'h00);
    wait_rsp(20, got, lat);
    checks += 3;
    if (lat != 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
    if (rsp_data !== 8'hFF) begin errors++; $display("FAIL rd_data: got %h want ff", rsp_data); end
    if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rd_timeout: got %b want 0", rsp_timeout); end
    @(negedge clk);
    checks += 2;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_strobe_len: got %b want 0", rsp_valid); end
    if (rsp_data !== 8'hFF) begin errors++; $display("FAIL rd_hold: got %h want ff", rsp_data); end
  endtask

  task automatic test_poll_match();
    bit got;
    int lat;
    int r0, s0;
    logic [7:0] d;
    send(3'd0, 3'd1, 8'h00, 8'h00);
    ext_pins = 8'h00;
    r0 = rd_total;
    s0 = rsp_total;
    send(3'd2, 3'd0, 8'h80, 8'h80);
    // reads land in cycles 1, 5, 9: pins change during the third read
    repeat (8) @(negedge clk);
    ext_pins = 8'h80;
    wait_rsp(40, got, lat);
    d = rsp_data;
    checks += 2;
    if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL pm_timeout: got %b want 0", rsp_timeout); end
    if (d[7] !== 1'b1) begin errors++; $display("FAIL pm_data7: got %h want bit7 set", d); end
    repeat (20) @(negedge clk);
    #1;
    checks += 2;
    if (rsp_total - s0 != 1) begin errors++; $display("FAIL pm_rsp_count: got %0d want 1", rsp_total - s0); end
    if (rd_total - r0 != 3) begin errors++; $display("FAIL pm_reads: got %0d want 3", rd_total - r0); end
    @(negedge clk);
  endtask

  task automatic test_poll_timeout();
    bit got;
    int lat;
    int r0, s0;
    ext_pins = 8'h00;
    r0 = rd_total;
    s0 = rsp_total;
    send(3'd2, 3'd0, 8'h01, 8'h01);
`ifdef PIO_MASTER_SEQ_TIMEOUT_EN
    wait_rsp(80, got, lat);
    checks += 2;
    if (rsp_timeout !== 1'b1) begin errors++; $display("FAIL pt_timeout: got %b want 1", rsp_timeout); end
    if (rsp_data !== 8'h00) begin errors++; $display("FAIL pt_data: got %h want 00", rsp_data); end
    repeat (10) @(negedge clk);
    #1;
    checks += 2;
    if (rd_total - r0 != TB_TIMEOUT) begin errors++; $display("FAIL pt_reads: got %0d want %0d", rd_total - r0, TB_TIMEOUT); end
    if (rsp_total - s0 != 1) begin errors++; $display("FAIL pt_rsp_count: got %0d want 1", rsp_total - s0); end
    for (int i = 1; i < TB_TIMEOUT; i++) begin
      checks++;
      // PA, PD, then POLL_GAP idle cycles between strobes
      if (rd_ncyc[r0+i] - rd_ncyc[r0+i-1] != TB_GAP + 2) begin
        errors++;
        $display("FAIL pt_spacing%0d: got %0d want %0d", i, rd_ncyc[r0+i] - rd_ncyc[r0+i-1], TB_GAP + 2);
      end
    end
`else
    repeat (60) @(negedge clk);
    #1;
    checks += 3;
    if (rsp_total != s0) begin errors++; $display("FAIL pi_no_rsp: got %0d want 0", rsp_total - s0); end
    if (rd_total - r0 < 10) begin errors++; $display("FAIL pi_reads: got %0d want >=10", rd_total - r0); end
    if (rd_ncyc[r0+2] - rd_ncyc[r0+1] != TB_GAP + 2) begin errors++; $display("FAIL pi_spacing: got %0d want %0d", rd_ncyc[r0+2] - rd_ncyc[r0+1], TB_GAP + 2); end
    @(negedge clk);
    ext_pins = 8'h01;
    wait_rsp(40, got, lat);
    checks += 2;
    if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL pi_timeout: got %b want 0", rsp_timeout); end
    if (rsp_data !== 8'h01) begin errors++; $display("FAIL pi_data: got %h want 01", rsp_data); end
    ext_pins = 8'h00;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got;
    int lat;
    int s0;
    send(3'd0, 3'd1, 8'h3C, 8'h00);
    // abort a write while its strobe is on the bus
    send(3'd0, 3'd0, 8'h55, 8'h00);
    checks++;
    if (!(chipselect === 1'b1 && write_n === 1'b0)) begin errors++; $display("FAIL rm_wr_active: got cs=%b wn=%b want 1/0", chipselect, write_n); end
    #2 reset_n = 1'b0;
    #1;
    checks += 5;
    if (chipselect !== 1'b0) begin errors++; $display("FAIL rm_wr_cs: got %b want 0", chipselect); end
    if (write_n !== 1'b1) begin errors++; $display("FAIL rm_wr_wn: got %b want 1", write_n); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_wr_ready: got %b want 0", cmd_ready); end
    if (address !== 3'd0) begin errors++; $display("FAIL rm_wr_addr: got %0d want 0", address); end
    if (writedata !== 32'h0) begin errors++; $display("FAIL rm_wr_wdata: got %h want 0", writedata); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // reset while the poll sits in its data phase
    ext_pins = 8'h00;
    s0 = rsp_total;
    send(3'd2, 3'd0, 8'h01, 8'h01);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks += 5;
    if (chipselect !== 1'b0) begin errors++; $display("FAIL rm_pd_cs: got %b want 0", chipselect); end
    if (write_n !== 1'b1) begin errors++; $display("FAIL rm_pd_wn: got %b want 1", write_n); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_pd_ready: got %b want 0", cmd_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_pd_rsp: got %b want 0", rsp_valid); end
    if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rm_pd_timeout: got %b want 0", rsp_timeout); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (rsp_total != s0) begin errors++; $display("FAIL rm_no_rsp: got %0d want 0", rsp_total - s0); end
    @(negedge clk);
    send(3'd1, 3'd1, 8'h00, 8'h00);
    wait_rsp(20, got, lat);
    checks += 3;
    if (lat != 3) begin errors++; $display("FAIL rm_rd_latency: got %0d want 3", lat); end
    if (rsp_data !== 8'h3C) begin errors++; $display("FAIL rm_rd_data: got %h want 3c", rsp_data); end
    if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rm_rd_timeout: got %b want 0", rsp_timeout); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_clr();
    test_reserved();
    test_read();
    test_poll_match();
    test_poll_timeout();
    test_reset_mid();
    checks++;
    if (wd_hi_err != 0) begin errors++; $display("FAIL wdata_upper: got %0d nonzero cycles want 0", wd_hi_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
